// File: rtl/apb_mst_bridge.sv
// rtl/apb_mst_bridge.sv - valid/ready request channel to APB4 master bridge with PREADY timeout
module apb_mst_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    srst,
  // request channel
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  input  logic [2:0]              req_prot,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  // APB master side
  output logic                    psel,
  output logic                    penable,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr,
  input  logic                    pready
);

  // A disabled timeout still needs a legal one-bit counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                    state_q;
  logic                      psel_q;
  logic                      penable_q;
  logic [ADDR_WIDTH-1:0]     paddr_q;
  logic                      pwrite_q;
  logic [DATA_WIDTH/8-1:0]   pstrb_q;
  logic [2:0]                pprot_q;
  logic [DATA_WIDTH-1:0]     pwdata_q;
  logic                      rsp_valid_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic                      rsp_err_q;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;
  logic                      timeout_hit;
  logic                      accept;

  // Accept only from registered state so rsp_ready never reaches req_ready combinationally.
  assign req_ready   = (state_q == IDLE) && !rsp_valid_q;
  assign accept      = req_valid && req_ready;
  assign cnt_d       = cnt_q + CW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Transfer FSM with registered APB outputs and the one-entry response buffer.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            paddr_q  <= req_addr;
            pwrite_q <= req_write;
            pwdata_q <= req_wdata;
            pstrb_q  <= req_write ? req_wstrb : '0;
            pprot_q  <= req_prot;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (!pwrite_q && !pslverr) ? prdata : '0;
            rsp_err_q   <= pslverr;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else if (timeout_hit) begin
            // Hung slave: release the bus and report an error; a late pready lands in IDLE and is ignored.
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mst_bridge.sv
// tb/tb_apb_mst_bridge.sv - randomized self-checking bench for apb_mst_bridge
module tb_apb_mst_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic [2:0]    req_prot;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pslverr;
  logic          pready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_mst_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .srst(srst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb),
    .pprot(pprot), .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr), .pready(pready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete transfer: request, slave with 'waits' wait states, response held 'hold' cycles.
  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] wstrb, input logic [2:0] prot, input int waits,
                         input logic serr, input logic [DW-1:0] srdata, input int hold,
                         input logic pend);
    logic          timed_out;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    logic [SW-1:0] exp_strb;
    int            exp_psel;
    int            psel_cnt;
    int            acc;
    int            lat;
    int            n;
    logic [DW-1:0] held_rdata;
    logic          held_err;

    timed_out = (waits >= TO);
    exp_err   = timed_out || serr;
    exp_rdata = (timed_out || wr || serr) ? '0 : srdata;
    exp_strb  = wr ? wstrb : '0;
    exp_psel  = timed_out ? (1 + TO) : (2 + waits);

    req_addr  = addr;
    req_write = wr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    req_prot  = prot;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("req_ready_wait", 1'b0, 1'b1);
    step();
    req_valid = 1'b0;

    psel_cnt = 0;
    acc      = 0;
    lat      = -1;
    for (int k = 0; k < 40; k++) begin
      pready  = 1'b0;
      pslverr = 1'($urandom);
      prdata  = $urandom;
      if (rsp_valid) begin
        lat = k;
        break;
      end
      if (psel) begin
        psel_cnt++;
        chk("penable_phase", penable, psel_cnt > 1);
        chk("apb_fields", {paddr, pwrite, pstrb, pprot, pwdata}, {addr, wr, exp_strb, prot, wdata});
        if (penable) begin
          if (acc == waits) begin
            pready  = 1'b1;
            pslverr = serr;
            prdata  = srdata;
          end
          acc++;
        end
      end
      step();
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    if (lat < 0) begin
      chk("rsp_valid_timeout", 1'b0, 1'b1);
      return;
    end
    chk("latency", lat, exp_psel);
    chk("psel_cycles", psel_cnt, exp_psel);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", rsp_err, exp_err);
    held_rdata = rsp_rdata;
    held_err   = rsp_err;

    if (timed_out) begin
      pready = 1'b1;
      prdata = $urandom;
      step();
      pready = 1'b0;
      chk("late_pready_psel", psel, 1'b0);
      chk("late_pready_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, {DW{1'b0}}});
    end

    for (int i = 0; i < hold; i++) begin
      if (pend) req_valid = 1'b1;
      step();
      chk("hold_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, held_err, held_rdata});
      chk("hold_req_ready", {req_ready, psel}, 2'b00);
    end

    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_consumed", rsp_valid, 1'b0);
    chk("req_ready_after_rsp", req_ready, 1'b1);
  endtask

  initial begin
    srst      = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_wstrb = '0;
    req_prot  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    pready    = 1'b0;
    repeat (3) step();

    chk("reset_apb", {psel, penable, paddr, pwrite, pstrb, pprot, pwdata}, '0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
    chk("reset_req_ready", req_ready, 1'b1);
    srst = 1'b0;
    step();

    // read, zero wait
    do_xfer(32'h1000_0004, 1'b0, 32'h0, 4'hF, 3'd2, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    // write, three wait states
    do_xfer(32'h2000_0010, 1'b1, 32'h1234_5678, 4'h3, 3'd1, 3, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
    // slave error on read
    do_xfer(32'h3000_0000, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    // slave never ready
    do_xfer(32'h4000_0008, 1'b0, 32'h0, 4'h0, 3'd7, 99, 1'b0, 32'h5555_AAAA, 0, 1'b0);
    // backpressure with a second request pending, then that request
    do_xfer(32'h5000_0000, 1'b0, 32'h0, 4'h0, 3'd3, 1, 1'b0, 32'h0BAD_F00D, 10, 1'b1);
    do_xfer(32'h5000_0004, 1'b1, 32'hA5A5_5A5A, 4'hC, 3'd4, 0, 1'b0, 32'h1111_2222, 0, 1'b0);

    // reset in the middle of an ACCESS wait state
    req_addr  = 32'h6000_0000;
    req_write = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("rst_mid_access", {psel, penable}, 2'b11);
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("rst_mid_apb", {psel, penable}, 2'b00);
    chk("rst_mid_rsp", rsp_valid, 1'b0);
    repeat (3) step();
    chk("rst_mid_no_rsp", {rsp_valid, psel}, 2'b00);
    do_xfer(32'h6000_0040, 1'b0, 32'h0, 4'h0, 3'd0, 2, 1'b0, 32'h7654_3210, 1, 1'b0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      do_xfer($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0), $urandom,
              int'($urandom_range(0, 3)), 1'($urandom));
    end
    req_valid = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
